// File: rtl/gpio_spi_host.sv
// gpio_spi_host: SPI mode-0 master issuing single-register R/W frames
// to the GPIO expander, with trailing sclk pulses for its APB clock.
// Ports: pclk/reset (sync, active-high); cmd_valid/ready/write/addr/wdata;
// rsp_valid/rsp_rdata; busy; sclk/mosi/ss (registered); miso.
module gpio_spi_host #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2,
  parameter int TAIL_CLKS  = 2
) (
  input  logic                  pclk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  ss
);

  localparam int FB = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int NB = FB + TAIL_CLKS;
  localparam int PW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(NB + 1);

  localparam logic [PW-1:0] PH_LAST   = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_FLAST = BW'(FB - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NB - 1);
  localparam logic [BW-1:0] CAP_FIRST = BW'(FB - DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_TAIL,
    S_HOLD,
    S_GAP
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         ph_q, ph_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [FB-1:0]         sh_q, sh_d;
  logic [DATA_WIDTH-1:0] rd_q, rd_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvld_q, rvld_d;
  logic                  busy_q, busy_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  ss_q, ss_d;
  logic                  ph_end;

  assign ph_end    = (ph_q == PH_LAST);
  assign cmd_ready = (state_q == S_IDLE) && !reset;

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    rd_d    = rd_q;
    rdata_d = rdata_q;
    rvld_d  = 1'b0;
    busy_d  = busy_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    ss_d    = ss_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          sh_d    = {cmd_write, cmd_addr,
                     cmd_write ? cmd_wdata : {DATA_WIDTH{1'b0}}};
          mosi_d  = cmd_write;
          ss_d    = 1'b0;
          sclk_d  = 1'b0;
          busy_d  = 1'b1;
          ph_d    = '0;
          bit_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (ph_end) begin
          ph_d    = '0;
          state_d = S_SHIFT;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_SHIFT, S_TAIL: begin
        if (!ph_end) begin
          ph_d = ph_q + 1'b1;
        end else if (!sclk_q) begin
          ph_d   = '0;
          sclk_d = 1'b1;
          // Only the data field is captured; read and write alike.
          if (state_q == S_SHIFT && bit_q >= CAP_FIRST)
            rd_d = {rd_q[DATA_WIDTH-2:0], miso};
        end else begin
          ph_d   = '0;
          sclk_d = 1'b0;
          // Zero fill makes mosi drop to 0 for the tail pulses.
          sh_d   = sh_q << 1;
          mosi_d = sh_q[FB-2];
          bit_d  = bit_q + 1'b1;
          if (bit_q == BIT_LAST)
            state_d = S_HOLD;
          else if (bit_q == BIT_FLAST)
            state_d = S_TAIL;
        end
      end
      S_HOLD: begin
        if (ph_end) begin
          ph_d    = '0;
          ss_d    = 1'b1;
          state_d = S_GAP;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_GAP: begin
        if (ph_end) begin
          ph_d    = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Response registered so it is visible during the last HOLD cycle.
    if (state_d == S_HOLD && ph_d == PH_LAST) begin
      rvld_d  = 1'b1;
      rdata_d = rd_d;
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      rd_q    <= '0;
      rdata_q <= '0;
      rvld_q  <= 1'b0;
      busy_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ss_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
      rvld_q  <= rvld_d;
      busy_q  <= busy_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ss_q    <= ss_d;
    end
  end

  assign rsp_valid = rvld_q;
  assign rsp_rdata = rdata_q;
  assign busy      = busy_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign ss        = ss_q;

endmodule

// File: tb/tb_gpio_spi_host.sv
// tb_gpio_spi_host: directed bench for gpio_spi_host, default build
// plus a CLK_DIV=1 / TAIL_CLKS=0 build sharing clock and reset.
module tb_gpio_spi_host;

  logic       clk = 1'b0;
  logic       reset;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;

  logic       cmd_valid, cmd_ready, cmd_write;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, busy, sclk, mosi, miso, ss;
  logic [7:0] rsp_rdata;

  logic       valid_b, ready_b, write_b;
  logic [6:0] addr_b;
  logic [7:0] wdata_b;
  logic       rvld_b, busy_b, sclk_b, mosi_b, ss_b;
  logic [7:0] rdata_b;

  int          rises = 0, falls = 0, rbase = 0, fbase = 0;
  logic [31:0] mosi_sr = '0;
  logic [15:0] sdata = '0;
  logic        tie1 = 1'b0;
  logic [3:0]  sidx;

  int          rises_b = 0, last_b = 0, prev_b = 0;
  logic [31:0] msr_b = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  gpio_spi_host dut (
    .pclk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .sclk(sclk), .mosi(mosi), .miso(miso), .ss(ss)
  );

  gpio_spi_host #(.CLK_DIV(1), .TAIL_CLKS(0)) dut_b (
    .pclk(clk), .reset(reset),
    .cmd_valid(valid_b), .cmd_ready(ready_b),
    .cmd_write(write_b), .cmd_addr(addr_b), .cmd_wdata(wdata_b),
    .rsp_valid(rvld_b), .rsp_rdata(rdata_b), .busy(busy_b),
    .sclk(sclk_b), .mosi(mosi_b), .miso(1'b0), .ss(ss_b)
  );

  always @(posedge sclk) begin
    mosi_sr = {mosi_sr[30:0], mosi};
    rises++;
  end
  always @(negedge sclk) falls++;

  always @(posedge sclk_b) begin
    msr_b = {msr_b[30:0], mosi_b};
    rises_b++;
    prev_b = last_b;
    last_b = cyc;
  end

  // Slave model: shifts sdata out MSB first, advancing on sclk fall.
  always_comb begin
    sidx = 4'(15 - (falls - fbase));
    if (tie1) miso = 1'b1;
    else if (falls - fbase < 16) miso = sdata[sidx];
    else miso = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic w, input logic [6:0] a,
                        input logic [7:0] d, output int acc);
    acc = -1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    rbase = rises;
    fbase = falls;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        acc = cyc;
        break;
      end
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    if (acc < 0) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(output int c);
    c = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        c = cyc;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, c, r, hi, rise_c, seen;
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    valid_b = 1'b0; write_b = 1'b0; addr_b = '0; wdata_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ss", 32'(ss), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rvld", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rel_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;

    // Write 0x05 / 0xA5
    send_a(1'b1, 7'h05, 8'hA5, acc);
    chk("wr_busy", 32'(busy), 32'd1);
    wait_rsp(c);
    chk("wr_rsp_cyc", 32'(c - acc), 32'd76);
    chk("wr_rsp_rdy", 32'(cmd_ready), 32'd0);
    chk("wr_rises", 32'(rises - rbase), 32'd18);
    chk("wr_mosi", mosi_sr & 32'h3FFFF, {14'd0, 16'h85A5, 2'b00});
    @(negedge clk);
    chk("wr_rsp_pulse", 32'(rsp_valid), 32'd0);
    r = -1;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) begin
        r = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("wr_ready_cyc", 32'(r - acc), 32'd79);
    @(posedge clk); #1;

    // Read 0x7F, slave returns 0x3C
    sdata = 16'h003C;
    send_a(1'b0, 7'h7F, 8'hEE, acc);
    wait_rsp(c);
    chk("rd_rsp_cyc", 32'(c - acc), 32'd76);
    chk("rd_rdata", 32'(rsp_rdata), 32'h3C);
    chk("rd_mosi", mosi_sr & 32'h3FFFF, {14'd0, 16'h7F00, 2'b00});
    repeat (10) @(negedge clk);
    chk("rd_hold", 32'(rsp_rdata), 32'h3C);
    @(posedge clk); #1;

    // Back-to-back: write 0x01/0x11 then read 0x02
    sdata = 16'h005A;
    cmd_write = 1'b1; cmd_addr = 7'h01; cmd_wdata = 8'h11;
    cmd_valid = 1'b1;
    rbase = rises;
    acc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        acc = cyc;
        break;
      end
    end
    @(posedge clk);
    #1 cmd_addr = 7'h55; cmd_wdata = 8'h66;
    repeat (20) @(posedge clk);
    #1 cmd_write = 1'b0; cmd_addr = 7'h02; cmd_wdata = 8'hFF;
    rise_c = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ss) begin
        rise_c = cyc;
        break;
      end
    end
    chk("b2b_ss_rise", 32'(rise_c - acc), 32'd77);
    chk("b2b_f1_rises", 32'(rises - rbase), 32'd18);
    chk("b2b_f1_mosi", mosi_sr & 32'h3FFFF, {14'd0, 16'h8111, 2'b00});
    hi = 0;
    acc2 = -1;
    for (int i = 0; i < 20; i++) begin
      if (!ss) break;
      hi++;
      if (cmd_ready) acc2 = cyc;
      fbase = falls;
      rbase = rises;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("b2b_ss_high", 32'(hi), 32'd3);
    chk("b2b_acc2", 32'(acc2 - acc), 32'd79);
    wait_rsp(c);
    chk("b2b_rsp_cyc", 32'(c - acc2), 32'd76);
    chk("b2b_rdata", 32'(rsp_rdata), 32'h5A);
    chk("b2b_f2_mosi", mosi_sr & 32'h3FFFF, {14'd0, 16'h0200, 2'b00});
    repeat (8) @(posedge clk); #1;

    // Reset during SHIFT
    send_a(1'b1, 7'h44, 8'h77, acc);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rises - rbase >= 7) break;
    end
    reset = 1'b1;
    @(negedge clk);
    chk("ab_ss", 32'(ss), 32'd1);
    chk("ab_sclk", 32'(sclk), 32'd0);
    chk("ab_mosi", 32'(mosi), 32'd0);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_ready", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("ab_no_rsp", 32'(seen), 32'd0);
    chk("ab_rdata", 32'(rsp_rdata), 32'd0);
    @(posedge clk); #1;
    send_a(1'b1, 7'h10, 8'h33, acc);
    wait_rsp(c);
    chk("ab_rsp_cyc", 32'(c - acc), 32'd76);
    chk("ab_mosi_frame", mosi_sr & 32'h3FFFF, {14'd0, 16'h9033, 2'b00});
    repeat (6) @(posedge clk); #1;

    // miso tied high during a write
    tie1 = 1'b1;
    send_a(1'b1, 7'h20, 8'h0F, acc);
    wait_rsp(c);
    chk("t1_rdata", 32'(rsp_rdata), 32'hFF);
    tie1 = 1'b0;
    repeat (6) @(posedge clk); #1;

    // CLK_DIV=1, TAIL_CLKS=0 build
    write_b = 1'b1; addr_b = 7'h00; wdata_b = 8'hFF; valid_b = 1'b1;
    rbase = rises_b;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ready_b) begin
        acc = cyc;
        break;
      end
    end
    @(posedge clk);
    #1 valid_b = 1'b0;
    c = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rvld_b) begin
        c = cyc;
        break;
      end
    end
    chk("b_rsp_cyc", 32'(c - acc), 32'd34);
    chk("b_rises", 32'(rises_b - rbase), 32'd16);
    chk("b_mosi", msr_b & 32'hFFFF, 32'h80FF);
    chk("b_period", 32'(last_b - prev_b), 32'd2);
    chk("b_rdata", 32'(rdata_b), 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
